// File: rtl/decode_pkg.sv
// Shared decode-stage types: opclass encoding, RV32I major opcodes and the
// decoded-entry record stored in the decode buffer.
package decode_pkg;

  typedef enum logic [3:0] {
    OC_ALU_R   = 4'd0,
    OC_ALU_I   = 4'd1,
    OC_LOAD    = 4'd2,
    OC_STORE   = 4'd3,
    OC_BRANCH  = 4'd4,
    OC_JAL     = 4'd5,
    OC_JALR    = 4'd6,
    OC_LUI     = 4'd7,
    OC_AUIPC   = 4'd8,
    OC_SYSTEM  = 4'd9,
    OC_ILLEGAL = 4'd15
  } opclass_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    opclass_e    opclass;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
  } dec_entry_t;

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I field and immediate extraction for one instruction.
module rv32i_decoder
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output dec_entry_t  entry
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  always_comb begin
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {instr[31:12], 12'b0};
    imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  always_comb begin
    entry         = '0;
    entry.pc      = pc;
    entry.instr   = instr;
    entry.rd      = instr[11:7];
    entry.rs1     = instr[19:15];
    entry.rs2     = instr[24:20];
    entry.opclass = OC_ILLEGAL;
    entry.imm     = '0;
    if (instr[1:0] == 2'b11) begin
      unique case (instr[6:0])
        OPC_OP:     entry.opclass = OC_ALU_R;
        OPC_OP_IMM: begin entry.opclass = OC_ALU_I;   entry.imm = imm_i; end
        OPC_LOAD:   begin entry.opclass = OC_LOAD;    entry.imm = imm_i; end
        OPC_STORE:  begin entry.opclass = OC_STORE;   entry.imm = imm_s; end
        OPC_BRANCH: begin entry.opclass = OC_BRANCH;  entry.imm = imm_b; end
        OPC_JAL:    begin entry.opclass = OC_JAL;     entry.imm = imm_j; end
        OPC_JALR:   begin entry.opclass = OC_JALR;    entry.imm = imm_i; end
        OPC_LUI:    begin entry.opclass = OC_LUI;     entry.imm = imm_u; end
        OPC_AUIPC:  begin entry.opclass = OC_AUIPC;   entry.imm = imm_u; end
        OPC_SYSTEM: begin entry.opclass = OC_SYSTEM;  entry.imm = imm_i; end
        default:    entry.opclass = OC_ILLEGAL;
      endcase
    end
    entry.illegal = (entry.opclass == OC_ILLEGAL);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: RV32I decode into a DEPTH-entry buffer with a valid/ready
// output, JAL resolution at decode and wrong-path draining after redirects.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [31:0] dec_instr,
  input  logic [31:0] dec_pc,
  output logic        dec_read_en,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [3:0]  id_opclass,
  output logic [31:0] id_imm,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic        id_illegal,
  input  logic        ex_flush,
  input  logic [31:0] ex_target,
  output logic        branch_resolved,
  output logic        branch_taken,
  output logic [31:0] branch_pc,
  output logic [31:0] branch_target
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] expected_q, expected_d;
  logic [CW-1:0] count_q;
  logic [PW-1:0] head_q, tail_q;
  dec_entry_t  fifo_q [DEPTH];
  dec_entry_t  dec_e, head_e;
  logic        accept, push, pop, jal_fire;
  logic [31:0] jal_target;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  rv32i_decoder u_dec (
    .instr (dec_instr),
    .pc    (dec_pc),
    .entry (dec_e)
  );

  always_comb begin
    head_e      = fifo_q[head_q];
    id_valid    = (count_q != '0);
    id_pc       = head_e.pc;
    id_instr    = head_e.instr;
    id_opclass  = head_e.opclass;
    id_imm      = head_e.imm;
    id_rd       = head_e.rd;
    id_rs1      = head_e.rs1;
    id_rs2      = head_e.rs2;
    id_illegal  = head_e.illegal;
    dec_read_en = (count_q < DEPTH_C) && !rst && (state_q != FLUSH);
    accept      = dec_valid && dec_read_en;
    jal_target  = dec_pc + dec_e.imm;
    pop         = id_valid && id_ready && !ex_flush;
  end

  // Out of RUN only the instruction at expected_pc is kept; it also
  // resumes RUN in the same cycle so a correct redirect costs no bubble.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    push       = 1'b0;
    jal_fire   = 1'b0;
    if (ex_flush) begin
      state_d    = FLUSH;
      expected_d = ex_target;
    end else if (state_q == FLUSH) begin
      state_d = DRAIN;
    end else if (accept && (state_q == RUN || dec_pc == expected_q)) begin
      push    = 1'b1;
      state_d = RUN;
      if (dec_e.opclass == OC_JAL) begin
        jal_fire   = 1'b1;
        state_d    = DRAIN;
        expected_d = jal_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      expected_q      <= '0;
      count_q         <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      fifo_q          <= '{default: '0};
      branch_resolved <= 1'b0;
      branch_taken    <= 1'b0;
      branch_pc       <= '0;
      branch_target   <= '0;
    end else begin
      state_q         <= state_d;
      expected_q      <= expected_d;
      branch_resolved <= jal_fire;
      branch_taken    <= jal_fire;
      if (jal_fire) begin
        branch_pc     <= dec_pc;
        branch_target <= jal_target;
      end
      if (ex_flush) begin
        count_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
      end else begin
        if (push) begin
          fifo_q[tail_q] <= dec_e;
          tail_q         <= inc_ptr(tail_q);
        end
        if (pop) head_q <= inc_ptr(head_q);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run, all scored against a queue-based reference model of the stage.
module tb_decode_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_valid = 1'b0;
  logic [31:0] dec_instr = '0;
  logic [31:0] dec_pc = '0;
  logic        id_ready = 1'b0;
  logic        ex_flush = 1'b0;
  logic [31:0] ex_target = '0;
  logic        dec_read_en, id_valid, id_illegal;
  logic [31:0] id_pc, id_instr, id_imm;
  logic [3:0]  id_opclass;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic        branch_resolved, branch_taken;
  logic [31:0] branch_pc, branch_target;

  decode_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_read_en(dec_read_en), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_opclass(id_opclass), .id_imm(id_imm),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_illegal(id_illegal),
    .ex_flush(ex_flush), .ex_target(ex_target),
    .branch_resolved(branch_resolved), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  // Reference model: buffer as a queue, mode 0=run 1=drain 2=flush.
  ent_t        m_q[$];
  int          m_mode = 0;
  logic [31:0] m_exp = '0;
  bit          m_pend = 0;
  logic [31:0] m_bpc = '0, m_btgt = '0;
  bit          m_known = 0;
  bit          m_acc = 0;
  logic [31:0] delivered[$];
  int          vectors = 0;
  int          errors = 0;

  function automatic logic [31:0] sx(input longint v, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (v >= half) ? 32'(v - 2 * half) : 32'(v);
  endfunction

  function automatic void ref_decode(input logic [31:0] w, output logic [3:0] oc,
                                     output logic [31:0] imm);
    longint u = longint'(w);
    longint top = u / 2**31;
    oc = 4'd15;
    imm = '0;
    if (u % 4 == 3) begin
      case (u % 128)
        51:  oc = 4'd0;
        19:  begin oc = 4'd1; imm = sx(u / 2**20, 12); end
        3:   begin oc = 4'd2; imm = sx(u / 2**20, 12); end
        35:  begin oc = 4'd3; imm = sx((u / 2**25) * 32 + (u / 128) % 32, 12); end
        99:  begin oc = 4'd4;
               imm = sx(top * 4096 + ((u / 128) % 2) * 2048 + ((u / 2**25) % 64) * 32
                        + ((u / 256) % 16) * 2, 13); end
        111: begin oc = 4'd5;
               imm = sx(top * 2**20 + ((u / 4096) % 256) * 4096 + ((u / 2**20) % 2) * 2048
                        + ((u / 2**21) % 1024) * 2, 21); end
        103: begin oc = 4'd6; imm = sx(u / 2**20, 12); end
        55:  begin oc = 4'd7; imm = 32'((u / 4096) * 4096); end
        23:  begin oc = 4'd8; imm = 32'((u / 4096) * 4096); end
        115: begin oc = 4'd9; imm = sx(u / 2**20, 12); end
        default: oc = 4'd15;
      endcase
    end
  endfunction

  // One clock: score outputs against the model, then advance the model.
  task automatic step();
    logic [3:0]  oc;
    logic [31:0] imm;
    logic        ren_exp;
    logic [31:0] w;
    #1;
    ren_exp = m_known && !rst && (m_q.size() < DEPTH) && (m_mode != 2);
    if (m_known) begin
      vectors++;
      if (dec_read_en !== ren_exp) begin
        errors++; $display("FAIL dec_read_en: got %b want %b", dec_read_en, ren_exp);
      end
      vectors++;
      if (id_valid !== (m_q.size() != 0)) begin
        errors++; $display("FAIL id_valid: got %b want %b", id_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        w = m_q[0].instr;
        ref_decode(w, oc, imm);
        vectors++;
        if ({id_pc, id_instr, id_opclass, id_imm, id_rd, id_rs1, id_rs2, id_illegal} !==
            {m_q[0].pc, w, oc, imm, w[11:7], w[19:15], w[24:20], oc == 4'd15}) begin
          errors++;
          $display("FAIL head: got pc=%h ins=%h oc=%0d imm=%h rd=%0d rs1=%0d rs2=%0d ill=%b want pc=%h ins=%h oc=%0d imm=%h",
                   id_pc, id_instr, id_opclass, id_imm, id_rd, id_rs1, id_rs2, id_illegal,
                   m_q[0].pc, w, oc, imm);
        end
      end
      vectors++;
      if ({branch_resolved, branch_taken} !== {m_pend, m_pend}) begin
        errors++; $display("FAIL branch_pulse: got %b%b want %b%b",
                           branch_resolved, branch_taken, m_pend, m_pend);
      end
      if (m_pend) begin
        vectors++;
        if ({branch_pc, branch_target} !== {m_bpc, m_btgt}) begin
          errors++; $display("FAIL branch_addr: got %h/%h want %h/%h",
                             branch_pc, branch_target, m_bpc, m_btgt);
        end
      end
    end
    if (id_valid === 1'b1 && id_ready) delivered.push_back(id_pc);
    m_acc = dec_valid && ren_exp;
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_mode = 0; m_exp = '0; m_pend = 0; m_known = 1;
    end else if (ex_flush) begin
      m_q.delete(); m_mode = 2; m_exp = ex_target; m_pend = 0;
    end else begin
      m_pend = 0;
      if (m_q.size() != 0 && id_ready) void'(m_q.pop_front());
      if (m_mode == 2) m_mode = 1;
      else if (m_acc && (m_mode == 0 || dec_pc == m_exp)) begin
        m_q.push_back('{dec_pc, dec_instr});
        m_mode = 0;
        ref_decode(dec_instr, oc, imm);
        if (oc == 4'd5) begin
          m_pend = 1; m_bpc = dec_pc; m_btgt = dec_pc + imm; m_mode = 1; m_exp = m_btgt;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; dec_valid = 1'b0; ex_flush = 1'b0; id_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] ins);
    dec_valid = 1'b1; dec_pc = pc; dec_instr = ins;
    step();
    dec_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({id_valid, dec_read_en, id_pc, id_instr, id_imm} !== {1'b0, 1'b1, 96'd0}) begin
      errors++; $display("FAIL reset_state: got v=%b ren=%b pc=%h ins=%h imm=%h",
                         id_valid, dec_read_en, id_pc, id_instr, id_imm);
    end
  endtask

  task automatic test_addi();
    do_reset();
    offer(32'h0, 32'h0050_0093);
    vectors++;
    if ({id_valid, id_opclass, id_imm, id_rd} !== {1'b1, 4'd1, 32'd5, 5'd1}) begin
      errors++; $display("FAIL addi: got v=%b oc=%0d imm=%h rd=%0d want 1/1/5/1",
                         id_valid, id_opclass, id_imm, id_rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] p = 32'h0;
    do_reset();
    dec_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec_pc = p; dec_instr = 32'h0000_0013;
      step();
      if (m_acc) p += 4;
    end
    #1;
    vectors++;
    if ({dec_read_en, id_valid, id_pc} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL stall_hold: got ren=%b v=%b pc=%h want 0/1/0",
                         dec_read_en, id_valid, id_pc);
    end
    id_ready = 1'b1;
    delivered.delete();
    for (int i = 0; i < 6; i++) begin
      dec_valid = (p <= 32'h8); dec_pc = p;
      step();
      if (m_acc) p += 4;
    end
    dec_valid = 1'b0;
    vectors++;
    if (delivered.size() != 3 || delivered[0] !== 32'h0 || delivered[1] !== 32'h4 ||
        delivered[2] !== 32'h8) begin
      errors++; $display("FAIL order: got %0d pops first=%h want 0,4,8", delivered.size(),
                         delivered.size() ? delivered[0] : 32'hx);
    end
  endtask

  task automatic test_jal();
    do_reset();
    id_ready = 1'b1;
    delivered.delete();
    offer(32'h100, 32'h0100_006F);
    vectors++;
    if ({branch_resolved, branch_taken, branch_pc, branch_target} !==
        {2'b11, 32'h100, 32'h110}) begin
      errors++; $display("FAIL jal_pulse: got %b%b %h %h want 11 100 110",
                         branch_resolved, branch_taken, branch_pc, branch_target);
    end
    offer(32'h104, 32'h0000_0013);
    vectors++;
    if (branch_resolved !== 1'b0) begin
      errors++; $display("FAIL jal_one_cycle: got %b want 0", branch_resolved);
    end
    offer(32'h108, 32'h0000_0013);
    offer(32'h110, 32'h0000_0013);
    repeat (3) step();
    vectors++;
    if (delivered.size() != 2 || delivered[0] !== 32'h100 || delivered[1] !== 32'h110) begin
      errors++; $display("FAIL drain: got %0d delivered last=%h want 100,110",
                         delivered.size(), delivered.size() ? delivered[$] : 32'hx);
    end
  endtask

  task automatic test_flush();
    logic [31:0] pcs[3] = '{32'h1F0, 32'h200, 32'h204};
    int idx = 0;
    do_reset();
    offer(32'h0, 32'h0000_0013);
    offer(32'h4, 32'h0000_0013);
    id_ready = 1'b1; ex_flush = 1'b1; ex_target = 32'h200;
    offer(32'h8, 32'h0100_006F);
    ex_flush = 1'b0;
    delivered.delete();
    #1;
    vectors++;
    if ({id_valid, branch_resolved, dec_read_en} !== 3'b000) begin
      errors++; $display("FAIL flush_clear: got v=%b br=%b ren=%b want 000",
                         id_valid, branch_resolved, dec_read_en);
    end
    for (int i = 0; i < 8; i++) begin
      dec_valid = (idx < 3);
      dec_pc = pcs[idx < 3 ? idx : 2]; dec_instr = 32'h0000_0013;
      step();
      if (m_acc) idx++;
    end
    dec_valid = 1'b0;
    vectors++;
    if (delivered.size() != 2 || delivered[0] !== 32'h200 || delivered[1] !== 32'h204) begin
      errors++; $display("FAIL flush_redirect: got %0d delivered first=%h want 200,204",
                         delivered.size(), delivered.size() ? delivered[0] : 32'hx);
    end
  endtask

  task automatic test_illegal_negjal();
    do_reset();
    offer(32'h40, 32'h0000_0000);
    vectors++;
    if ({id_valid, id_opclass, id_illegal} !== {1'b1, 4'd15, 1'b1}) begin
      errors++; $display("FAIL illegal: got v=%b oc=%0d ill=%b want 1/15/1",
                         id_valid, id_opclass, id_illegal);
    end
    do_reset();
    offer(32'h0, 32'hFFDF_F06F);
    vectors++;
    if ({branch_resolved, branch_target} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL neg_jal: got br=%b tgt=%h want 1 fffffffc",
                         branch_resolved, branch_target);
    end
  endtask

  task automatic test_rst_in_drain();
    do_reset();
    offer(32'h0, 32'hFFDF_F06F);
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({id_valid, branch_resolved} !== 2'b00) begin
      errors++; $display("FAIL rst_drain: got v=%b br=%b want 00", id_valid, branch_resolved);
    end
    offer(32'h40, 32'h0000_0013);
    vectors++;
    if ({id_valid, id_pc} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL rst_run: got v=%b pc=%h want 1 40", id_valid, id_pc);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                            7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    logic [31:0] w = $urandom;
    int r = $urandom_range(0, 14);
    if (r < 10) w[6:0] = ops[r];
    else if (r < 13) w[6:0] = 7'h6F;
    else w[1:0] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  task automatic test_random();
    logic [31:0] ifu_pc = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      dec_valid = ($urandom_range(0, 3) != 0);
      id_ready  = ($urandom_range(0, 2) != 0);
      ex_flush  = ($urandom_range(0, 39) == 0);
      ex_target = 32'($urandom_range(0, 1023)) << 2;
      dec_pc    = ifu_pc;
      dec_instr = gen_instr();
      step();
      if (m_acc) ifu_pc = (m_mode == 1 && $urandom_range(0, 1) == 1) ? m_exp : ifu_pc + 4;
      else if (m_mode == 1 && $urandom_range(0, 3) == 0) ifu_pc = m_exp;
    end
    dec_valid = 1'b0; ex_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_backpressure();
    test_jal();
    test_flush();
    test_illegal_negjal();
    test_rst_in_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
